// File: rtl/multi_bank_sram.sv
// Word-interleaved multi-bank SRAM with per-bank round-robin arbitration between N request ports.
// Single-cycle grant, one-cycle response latency, byte-enabled writes, wrapping address decode.
module multi_bank_sram #(
    parameter int NUM_PORTS     = 2,
    parameter int NUM_BANKS     = 4,
    parameter int MEM_SIZE_BYTE = 32768,
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [NUM_PORTS-1:0]              req_i,
    input  logic [NUM_PORTS-1:0]              we_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   addr_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   wdata_i,
    output logic [NUM_PORTS-1:0]              gnt_o,
    output logic [NUM_PORTS-1:0]              rvalid_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]   rdata_o
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int WB    = $clog2(BYTES);
    localparam int BB    = $clog2(NUM_BANKS);
    localparam int BW    = (BB > 0) ? BB : 1;
    localparam int ROWS  = MEM_SIZE_BYTE / (NUM_BANKS * BYTES);
    localparam int RB    = $clog2(ROWS);
    localparam int RW    = (RB > 0) ? RB : 1;
    localparam int PW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]  w_req;
    logic [BW-1:0]         w_bank  [NUM_PORTS];
    logic [RW-1:0]         w_row   [NUM_PORTS];
    logic [BYTES-1:0]      w_be    [NUM_PORTS];
    logic [DATA_WIDTH-1:0] w_wdata [NUM_PORTS];

    logic [NUM_BANKS-1:0]  w_bank_busy;
    logic [PW-1:0]         w_bank_sel   [NUM_BANKS];
    logic [DATA_WIDTH-1:0] w_bank_rdata [NUM_BANKS];

    logic [NUM_PORTS-1:0]  r_rvalid;
    logic [NUM_PORTS-1:0]  r_wr;
    logic [BW-1:0]         r_rbank [NUM_PORTS];

    // Upper address bits are dropped on purpose (wrap), low bits because accesses are word-aligned.
    logic w_unused_addr;
    assign w_unused_addr = ^addr_i;

    // No grants while reset is asserted, even though requests may be raised.
    assign w_req = req_i & {NUM_PORTS{~rst_i}};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_decode
        assign w_bank[p]  = (BB > 0) ? addr_i[p*ADDR_WIDTH+WB +: BW] : '0;
        assign w_row[p]   = addr_i[p*ADDR_WIDTH+WB+BB +: RW];
        assign w_be[p]    = be_i[p*BYTES +: BYTES];
        assign w_wdata[p] = wdata_i[p*DATA_WIDTH +: DATA_WIDTH];
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [PW-1:0]         r_rr_ptr;
        logic [DATA_WIDTH-1:0] r_mem [ROWS];
        logic [DATA_WIDTH-1:0] r_rdata;
        logic                  w_busy;
        logic [PW-1:0]         w_sel;
        int                    w_idx;

        // First requester at or after the pointer (ascending, wrapping) wins the bank.
        always_comb begin
            w_busy = 1'b0;
            w_sel  = '0;
            w_idx  = 0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_idx = (int'(r_rr_ptr) + i) % NUM_PORTS;
                if (!w_busy && w_req[w_idx] && (w_bank[w_idx] == BW'(b))) begin
                    w_busy = 1'b1;
                    w_sel  = PW'(w_idx);
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                r_rr_ptr <= '0;
            end else if (w_busy) begin
                r_rr_ptr <= (int'(w_sel) == NUM_PORTS - 1) ? '0 : w_sel + 1'b1;
            end
        end

        always_ff @(posedge clk_i) begin
            if (w_busy) begin
                if (we_i[w_sel]) begin
                    for (int k = 0; k < BYTES; k++) begin
                        if (w_be[w_sel][k]) begin
                            r_mem[w_row[w_sel]][k*8 +: 8] <= w_wdata[w_sel][k*8 +: 8];
                        end
                    end
                end else begin
                    r_rdata <= r_mem[w_row[w_sel]];
                end
            end
        end

        assign w_bank_busy[b]  = w_busy;
        assign w_bank_sel[b]   = w_sel;
        assign w_bank_rdata[b] = r_rdata;
    end

    always_comb begin
        gnt_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            gnt_o[p] = w_req[p] && w_bank_busy[w_bank[p]] && (int'(w_bank_sel[w_bank[p]]) == p);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rvalid <= '0;
            r_wr     <= '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_rbank[p] <= '0;
            end
        end else begin
            r_rvalid <= gnt_o;
            r_wr     <= we_i & gnt_o;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_rbank[p] <= w_bank[p];
            end
        end
    end

    // The bank read register is only meaningful for the cycle right after a read transfer.
    always_comb begin
        rdata_o = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (r_rvalid[p] && !r_wr[p]) begin
                rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = w_bank_rdata[r_rbank[p]];
            end
        end
    end

    assign rvalid_o = r_rvalid;

endmodule

// File: tb/tb_multi_bank_sram.sv
// Bench for multi_bank_sram: table of single-cycle vectors with expected grants, a negedge
// monitor scoreboarding every response against a byte-level memory model, and corner sequences.
module tb_multi_bank_sram;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [1:0]  req_i;
    logic [1:0]  we_i;
    logic [63:0] addr_i;
    logic [7:0]  be_i;
    logic [63:0] wdata_i;
    logic [1:0]  gnt_o;
    logic [1:0]  rvalid_o;
    logic [63:0] rdata_o;

    always #5 clk_i = ~clk_i;

    multi_bank_sram #(
        .NUM_PORTS(2), .NUM_BANKS(4), .MEM_SIZE_BYTE(32768), .DATA_WIDTH(32), .ADDR_WIDTH(32)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
        .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o)
    );

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  we;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic [1:0]  gnt;
    } vec_t;

    vec_t        tbl [15];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          rv_count = 0;
    logic [31:0] exp_q0 [$];
    logic [31:0] exp_q1 [$];
    logic [1:0]  exp_v = 2'b00;
    logic [31:0] mdl [int];
    logic [31:0] act_d;
    logic [31:0] exp_d;
    int          widx;

    task automatic check(input string name, input int p, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s port%0d: got %h expected %h at %0t", name, p, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] we, input logic [31:0] a0,
                         input logic [31:0] a1, input logic [3:0] be0, input logic [3:0] be1,
                         input logic [31:0] wd0, input logic [31:0] wd1);
        req_i   = req;
        we_i    = we;
        addr_i  = {a1, a0};
        be_i    = {be1, be0};
        wdata_i = {wd1, wd0};
    endtask

    function automatic vec_t mk(input logic [1:0] req, input logic [1:0] we, input logic [31:0] a0,
                                input logic [31:0] a1, input logic [3:0] be0, input logic [3:0] be1,
                                input logic [31:0] wd0, input logic [31:0] wd1, input logic [1:0] gnt);
        vec_t v;
        v.req = req; v.we = we; v.a0 = a0; v.a1 = a1; v.be0 = be0; v.be1 = be1;
        v.wd0 = wd0; v.wd1 = wd1; v.gnt = gnt;
        return v;
    endfunction

    // Scoreboard: responses checked one cycle after each observed transfer.
    always @(negedge clk_i) begin
        for (int p = 0; p < 2; p++) begin
            act_d = rdata_o[p*32 +: 32];
            if (rst_i) begin
                check("rst_gnt", p, {31'b0, gnt_o[p]}, 32'd0);
                check("rst_rvalid", p, {31'b0, rvalid_o[p]}, 32'd0);
                check("rst_rdata", p, act_d, 32'd0);
                if (exp_v[p]) begin
                    if (p == 0) void'(exp_q0.pop_front());
                    else        void'(exp_q1.pop_front());
                end
                exp_v[p] = 1'b0;
            end else begin
                check("rvalid", p, {31'b0, rvalid_o[p]}, {31'b0, exp_v[p]});
                if (rvalid_o[p]) rv_count++;
                if (exp_v[p]) begin
                    if (p == 0) exp_d = exp_q0.pop_front();
                    else        exp_d = exp_q1.pop_front();
                    if (!$isunknown(exp_d)) check("rdata", p, act_d, exp_d);
                end else begin
                    check("rdata_idle", p, act_d, 32'd0);
                end
                exp_v[p] = req_i[p] & gnt_o[p];
                if (exp_v[p]) begin
                    widx = int'((addr_i[p*32 +: 32] & 32'h7FFF) >> 2);
                    if (we_i[p]) begin
                        if (mdl.exists(widx)) exp_d = mdl[widx];
                        else                  exp_d = 'x;
                        for (int k = 0; k < 4; k++) begin
                            if (be_i[p*4+k]) exp_d[k*8 +: 8] = wdata_i[p*32+k*8 +: 8];
                        end
                        mdl[widx] = exp_d;
                        exp_d = 32'd0;
                    end else begin
                        if (mdl.exists(widx)) exp_d = mdl[widx];
                        else                  exp_d = 'x;
                    end
                    if (p == 0) exp_q0.push_back(exp_d);
                    else        exp_q1.push_back(exp_d);
                end
            end
        end
    end

    initial begin
        tbl[0]  = mk(2'b01, 2'b01, 32'h10,   32'h0,    4'hF, 4'h0, 32'hDEADBEEF, 32'h0,        2'b01);
        tbl[1]  = mk(2'b01, 2'b00, 32'h10,   32'h0,    4'hF, 4'h0, 32'h0,        32'h0,        2'b01);
        tbl[2]  = mk(2'b01, 2'b01, 32'h20,   32'h0,    4'hF, 4'h0, 32'h11223344, 32'h0,        2'b01);
        tbl[3]  = mk(2'b01, 2'b01, 32'h20,   32'h0,    4'h2, 4'h0, 32'h0000AA00, 32'h0,        2'b01);
        tbl[4]  = mk(2'b01, 2'b00, 32'h20,   32'h0,    4'hF, 4'h0, 32'h0,        32'h0,        2'b01);
        tbl[5]  = mk(2'b10, 2'b00, 32'h0,    32'h8020, 4'h0, 4'hF, 32'h0,        32'h0,        2'b10);
        tbl[6]  = mk(2'b11, 2'b11, 32'h0,    32'h4,    4'hF, 4'hF, 32'hA5A50000, 32'h00005A5A, 2'b11);
        tbl[7]  = mk(2'b11, 2'b00, 32'h0,    32'h4,    4'hF, 4'hF, 32'h0,        32'h0,        2'b11);
        tbl[8]  = mk(2'b10, 2'b10, 32'h0,    32'h4,    4'h0, 4'h0, 32'h0,        32'hFFFFFFFF, 2'b10);
        tbl[9]  = mk(2'b10, 2'b00, 32'h0,    32'h4,    4'h0, 4'hF, 32'h0,        32'h0,        2'b10);
        tbl[10] = mk(2'b11, 2'b00, 32'h10,   32'h0,    4'hF, 4'hF, 32'h0,        32'h0,        2'b10);
        tbl[11] = mk(2'b01, 2'b00, 32'h10,   32'h0,    4'hF, 4'h0, 32'h0,        32'h0,        2'b01);
        tbl[12] = mk(2'b11, 2'b01, 32'h24,   32'h20,   4'hF, 4'hF, 32'h01020304, 32'h0,        2'b11);
        tbl[13] = mk(2'b01, 2'b01, 32'h24,   32'h0,    4'h9, 4'h0, 32'hAB0000CD, 32'h0,        2'b01);
        tbl[14] = mk(2'b01, 2'b00, 32'h24,   32'h0,    4'hF, 4'h0, 32'h0,        32'h0,        2'b01);

        // Reset held with every port requesting: monitor expects all outputs low.
        drive(2'b11, 2'b00, 32'h0, 32'h10, 4'hF, 4'hF, 32'h0, 32'h0);
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        drive(2'b00, 2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);

        for (int i = 0; i < 15; i++) begin
            @(posedge clk_i); #1;
            drive(tbl[i].req, tbl[i].we, tbl[i].a0, tbl[i].a1, tbl[i].be0, tbl[i].be1, tbl[i].wd0, tbl[i].wd1);
            @(negedge clk_i);
            check($sformatf("tbl_gnt[%0d]", i), 0, {30'b0, gnt_o}, {30'b0, tbl[i].gnt});
        end
        @(posedge clk_i); #1;
        drive(2'b00, 2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk_i);

        // Fresh reset so both round-robin pointers restart at port 0.
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        rv_count = 0;
        drive(2'b11, 2'b00, 32'h0, 32'h10, 4'hF, 4'hF, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check($sformatf("conflict_gnt[%0d]", i), 0, {30'b0, gnt_o}, (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        @(posedge clk_i); #1;
        drive(2'b00, 2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk_i);
        #1;
        check("conflict_rvalid_count", 0, rv_count, 32'd4);

        // Reset lands between the read grant and the edge that would launch its response.
        @(posedge clk_i); #1;
        drive(2'b01, 2'b00, 32'h20, 32'h0, 4'hF, 4'h0, 32'h0, 32'h0);
        @(negedge clk_i);
        check("midrst_gnt", 0, {31'b0, gnt_o[0]}, 32'd1);
        #1;
        rst_i = 1'b1;
        drive(2'b00, 2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        rv_count = 0;
        repeat (3) @(negedge clk_i);
        #1;
        check("midrst_no_rvalid", 0, rv_count, 32'd0);

        @(posedge clk_i); #1;
        drive(2'b01, 2'b00, 32'h20, 32'h0, 4'hF, 4'h0, 32'h0, 32'h0);
        @(negedge clk_i);
        check("post_rst_gnt_a", 0, {31'b0, gnt_o[0]}, 32'd1);
        @(posedge clk_i); #1;
        drive(2'b01, 2'b00, 32'h10, 32'h0, 4'hF, 4'h0, 32'h0, 32'h0);
        @(negedge clk_i);
        check("post_rst_gnt_b", 0, {31'b0, gnt_o[0]}, 32'd1);
        @(posedge clk_i); #1;
        drive(2'b00, 2'b00, 32'h0, 32'h0, 4'h0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(negedge clk_i);
        #1;
        check("queues_drained", 0, exp_q0.size() + exp_q1.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_bank_sram.md
Name: multi_bank_sram

Overview:
- N-port, word-interleaved, multi-bank on-chip SRAM with OBI-style request/grant/response per port.
- Next generation of the dual-port scratchpad: generalised to NUM_PORTS masters and NUM_BANKS banks.
- Adds per-bank round-robin arbitration for bank conflicts, byte enables and address wrap.
- Sits between the GPU compute-unit/DMA request ports and shared local memory.

Parameters:
- NUM_PORTS, 2, number of master ports (>=1).
- NUM_BANKS, 4, number of banks; power of two, >=1.
- MEM_SIZE_BYTE, 32768, total capacity in bytes; power of two, divisible by NUM_BANKS*DATA_WIDTH/8.
- DATA_WIDTH, 32, word width in bits; multiple of 8.
- ADDR_WIDTH, 32, byte-address width.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_i  in  NUM_PORTS  per-port request.
- we_i  in  NUM_PORTS  per-port write enable (1 = write).
- addr_i  in  NUM_PORTS*ADDR_WIDTH  per-port byte address; port p is at slice p.
- be_i  in  NUM_PORTS*DATA_WIDTH/8  per-port byte enables.
- wdata_i  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- gnt_o  out  NUM_PORTS  per-port grant, combinational.
- rvalid_o  out  NUM_PORTS  per-port response valid.
- rdata_o  out  NUM_PORTS*DATA_WIDTH  per-port read data.

Behaviour:
- Interface: one clock (clk_i); reset rst_i is asynchronous and active-high.
- Address decode:
  - WB = log2(DATA_WIDTH/8).
  - bank = addr[WB +: log2(NUM_BANKS)].
  - row = next log2(MEM_SIZE_BYTE/(NUM_BANKS*DATA_WIDTH/8)) bits.
  - Upper bits are ignored, so addresses wrap modulo MEM_SIZE_BYTE.
  - Low WB bits are ignored; accesses are word-aligned.
- Handshake:
  - A transfer occurs on a cycle where req_i[p] && gnt_o[p].
  - gnt_o is combinational from req_i, addr_i and arbiter state.
  - A master holds req/addr/we/be/wdata stable until granted.
- Arbitration, per bank independently:
  - Among requesting ports targeting the bank, grant exactly one.
  - Priority search starts at rr_ptr[bank] and proceeds ascending with wrap.
  - On a grant to port g, rr_ptr[bank] <= (g+1) mod NUM_PORTS.
  - rr_ptr is unchanged when the bank is idle.
  - Requests to different banks are granted in the same cycle.
- Write: on transfer, bytes with be=1 are updated at the clock edge; bytes with be=0 are untouched. be=0 is a legal no-op write and still gets a response.
- Read: on transfer, the word is read at the clock edge.
- Response:
  - rvalid_o[p] is high exactly one cycle after each transfer, for reads and writes alike.
  - Reads: rdata_o[p] = word contents as of before any write in the transfer cycle.
  - Writes: rdata_o[p] = 0.
  - When rvalid_o[p] = 0, rdata_o[p] = 0.
- Throughput: one transfer per port per cycle when conflict-free; back-to-back supported.
- Read-after-write: a read granted the cycle after a write to the same address returns the new data.
- Same-address same-cycle access from two ports cannot occur; the bank serialises it.
- Reset:
  - Outputs: gnt_o=0, rvalid_o=0, rdata_o=0, all rr_ptr=0.
  - Reset asserted mid-operation drops any pending response; no rvalid is issued for that transfer.
  - Memory array is not reset; contents after power-up are undefined.
- State per bank: rr_ptr register, plus per-port response-valid and write-flag pipeline registers.
- Storage: one single-port array per bank; no bank is accessed twice per cycle.

Test Plan:
- Reset: hold rst_i=1 with req_i=all ones -> gnt_o=0, rvalid_o=0, rdata_o=0; after release, rr_ptr behaviour starts from port 0.
- Write/read, defaults: port0 writes addr 0x10 data 0xDEADBEEF be=0xF, then reads 0x10 -> rvalid one cycle after each gnt; read rdata=0xDEADBEEF; write response rdata=0.
- Byte enables and wrap:
  - Write 0x11223344 to 0x20, then be=0x2 wdata 0x0000AA00.
  - Read 0x20 -> 0x1122AA44.
  - Read 0x8020 -> 0x1122AA44 (wrap).
- Parallel no conflict: port0 reads 0x0 and port1 reads 0x4 (banks 0 and 1) in the same cycle -> both gnt_o=1 in that cycle; both rvalid next cycle.
- Conflict fairness:
  - Ports 0 and 1 continuously request 0x0 and 0x10 (both bank 0) for 4 cycles.
  - Grants go p0, p1, p0, p1; exactly one gnt per cycle.
  - Exactly 4 rvalid pulses total.
- Reset mid-read: assert rst_i in the cycle after port0's read gnt -> rvalid_o[0] never rises for that read; memory contents written earlier are preserved.
